// File: rtl/uart_tx_cfg_if.sv
// ============================================================================
// Module      : uart_tx_cfg_if
// Description : Word handshake between a producer and the uart_tx_cfg
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module      : uart_tx_cfg
// Description : Configurable UART transmitter (5..9 data bits, optional
//               even/odd parity, one or two stop bits, runtime bit period).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PRESC_W   = 16
) (
    input  wire                clock,
    input  wire                reset,
    input  wire  [PRESC_W-1:0] prescaler,
    input  wire  [1:0]         parity_mode,
    input  wire                two_stop,
    uart_tx_cfg_if.slave       bus,
    output logic               tx_pin,
    output logic               busy,
    output logic               done
);

    localparam int c_IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [PRESC_W-1:0]   r_timer;
    logic [PRESC_W-1:0]   r_reload;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_par_en;
    logic                 r_two_stop;
    logic                 r_pin;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ready;

    logic                 w_accept;
    logic [PRESC_W-1:0]   w_p_m1;
    logic [2:0]           w_state;
    logic [PRESC_W-1:0]   w_timer;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_stop_idx;
    logic [DATA_BITS-1:0] w_shift;
    logic                 w_pin;
    logic                 w_done;

    // The timer holds P-1 and counts down, so P = 2^PRESC_W-1 never overflows.
    always_comb begin
        w_accept   = r_ready && bus.tx_valid;
        w_p_m1     = (prescaler == '0) ? '0 : prescaler - 1'b1;
        w_state    = r_state;
        w_timer    = r_timer;
        w_idx      = r_idx;
        w_stop_idx = r_stop_idx;
        w_shift    = r_shift;

        if (r_state == c_S_IDLE) begin
            if (w_accept) begin
                w_state    = c_S_START;
                w_timer    = w_p_m1;
                w_idx      = '0;
                w_stop_idx = 1'b0;
                w_shift    = bus.tx_data;
            end
        end else if (r_timer != '0) begin
            w_timer = r_timer - 1'b1;
        end else begin
            w_timer = r_reload;
            case (r_state)
                c_S_START: begin
                    w_state = c_S_DATA;
                    w_idx   = '0;
                end
                c_S_DATA: begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state    = r_par_en ? c_S_PARITY : c_S_STOP;
                        w_stop_idx = 1'b0;
                    end else begin
                        w_idx   = r_idx + 1'b1;
                        w_shift = r_shift >> 1;
                    end
                end
                c_S_PARITY: begin
                    w_state    = c_S_STOP;
                    w_stop_idx = 1'b0;
                end
                c_S_STOP: begin
                    if (r_two_stop && !r_stop_idx) begin
                        w_stop_idx = 1'b1;
                    end else begin
                        w_state = c_S_IDLE;
                        w_timer = '0;
                        w_idx   = '0;
                    end
                end
                default: begin
                    w_state = c_S_IDLE;
                    w_timer = '0;
                    w_idx   = '0;
                end
            endcase
        end

        case (w_state)
            c_S_START:  w_pin = 1'b0;
            c_S_DATA:   w_pin = w_shift[0];
            c_S_PARITY: w_pin = r_par_bit;
            default:    w_pin = 1'b1;
        endcase

        // Done marks the last cycle of the final stop bit.
        w_done = (w_state == c_S_STOP) && (w_timer == '0) &&
                 (w_stop_idx || !r_two_stop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_timer    <= '0;
            r_reload   <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_pin      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_idx      <= w_idx;
            r_stop_idx <= w_stop_idx;
            r_shift    <= w_shift;
            r_pin      <= w_pin;
            r_busy     <= (w_state != c_S_IDLE);
            r_done     <= w_done;
            r_ready    <= (w_state == c_S_IDLE);
            if (w_accept) begin
                r_reload   <= w_p_m1;
                r_par_bit  <= (^bus.tx_data) ^ (parity_mode == 2'b10);
                r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_two_stop <= two_stop;
            end
        end
    end

    assign tx_pin       = r_pin;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bus.tx_ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] prescaler = 16'd1;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic        tx_pin, busy, done;

    logic        reset5 = 1'b1;
    logic [2:0]  presc5 = 3'd1;
    logic        tx_pin5, busy5, done5;

    int errors = 0;
    int checks = 0;

    uart_tx_cfg_if #(.DATA_BITS(8)) bus ();
    uart_tx_cfg_if #(.DATA_BITS(5)) bus5 ();

    uart_tx_cfg #(.DATA_BITS(8), .PRESC_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .prescaler   (prescaler),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .bus         (bus.slave),
        .tx_pin      (tx_pin),
        .busy        (busy),
        .done        (done)
    );

    uart_tx_cfg #(.DATA_BITS(5), .PRESC_W(3)) dut5 (
        .clock       (clock),
        .reset       (reset5),
        .prescaler   (presc5),
        .parity_mode (2'b00),
        .two_stop    (1'b0),
        .bus         (bus5.slave),
        .tx_pin      (tx_pin5),
        .busy        (busy5),
        .done        (done5)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- frame-level reference model ----------------
    // Expected outputs per cycle packed as {tx_pin, busy, done, tx_ready}.
    localparam logic [3:0] c_IDLE_OBS = 4'b1001;
    logic [3:0] exp_now = c_IDLE_OBS;
    logic [3:0] exp_q[$];
    bit         model_live = 0;

    function automatic void build_frame(input logic [7:0] d, input int p_raw,
                                        input logic [1:0] mode, input logic two);
        int p;
        bit bits[$];
        p = (p_raw == 0) ? 1 : p_raw;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (mode == 2'b01) bits.push_back(^d);
        if (mode == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++)
            for (int c = 0; c < p; c++)
                exp_q.push_back({bits[j], 1'b1,
                                 (j == bits.size() - 1) && (c == p - 1), 1'b0});
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            exp_now = c_IDLE_OBS;
        end else if (exp_now[0] && bus.tx_valid) begin
            build_frame(bus.tx_data, int'(prescaler), parity_mode, two_stop);
            exp_now = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            exp_now = exp_q.pop_front();
        end else begin
            exp_now = c_IDLE_OBS;
        end
        model_live = 1;
    end

    always @(negedge clock) begin
        if (model_live)
            chk("model_cmp", {60'd0, tx_pin, busy, done, bus.tx_ready}, {60'd0, exp_now});
    end

    // ---------------- line recorder for literal checks ----------------
    bit rec_q[$];
    int done_cnt = 0;
    always @(negedge clock) begin
        if (busy) rec_q.push_back(tx_pin);
        if (done) done_cnt++;
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("done_timeout", n < 2000, 1);
    endtask

    task automatic send_wait(input logic [7:0] d, input logic [15:0] p,
                             input logic [1:0] m, input logic two);
        rec_q.delete();
        done_cnt = 0;
        bus.tx_data = d; prescaler = p; parity_mode = m; two_stop = two;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'($urandom);
        prescaler = 16'($urandom_range(0, 9));
        parity_mode = 2'($urandom);
        two_stop = 1'($urandom);
        wait_done();
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [9:0] sample10(input int base, input int p);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = rec_q[base + p * i + (p - 1) / 2];
        return v;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [6:0] line5;
        int n;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        bus5.tx_valid = 1'b0; bus5.tx_data = 5'h00;
        repeat (3) @(negedge clock);
        chk("reset_state", {tx_pin, busy, done, bus.tx_ready}, 4'b1001);
        reset = 1'b0;
        reset5 = 1'b0;
        @(negedge clock);

        // 0xA5, P=4, no parity, one stop
        send_wait(8'hA5, 16'd4, 2'b00, 1'b0);
        chk("a5_len", rec_q.size(), 40);
        chk("a5_line", sample10(0, 4), 10'b1101001010);
        chk("a5_done_count", done_cnt, 1);
        chk("a5_ready_back", bus.tx_ready, 1);

        // Parity frames at P=2
        send_wait(8'h07, 16'd2, 2'b01, 1'b0);
        chk("even_len", rec_q.size(), 22);
        chk("even_par_bit", rec_q[18], 1);
        send_wait(8'h03, 16'd2, 2'b10, 1'b0);
        chk("odd_len", rec_q.size(), 22);
        chk("odd_par_bit", rec_q[18], 1);

        // prescaler 0 acts as 1, two stop bits
        send_wait(8'h00, 16'd0, 2'b00, 1'b1);
        chk("p0_len", rec_q.size(), 11);
        chk("p0_tail", {rec_q[8], rec_q[9], rec_q[10]}, 3'b011);

        // parity_mode 11 behaves as none
        send_wait(8'hFF, 16'd1, 2'b11, 1'b0);
        chk("mode3_len", rec_q.size(), 10);

        // Held tx_valid with inputs changed after accept
        rec_q.delete(); done_cnt = 0;
        bus.tx_data = 8'h55; prescaler = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_data = 8'h0F; prescaler = 16'd5;
        wait_done();
        @(negedge clock);
        chk("gap_cycle", {tx_pin, busy, bus.tx_ready}, 3'b101);
        chk("first_len", rec_q.size(), 30);
        chk("first_line", sample10(0, 3), 10'b1010101010);
        @(negedge clock);
        chk("second_accept", {tx_pin, busy, bus.tx_ready}, 3'b010);
        bus.tx_valid = 1'b0;
        wait_done();
        repeat (2) @(negedge clock);
        chk("second_len", rec_q.size(), 80);
        chk("second_line", sample10(30, 5), 10'b1000011110);

        // Reset during data bit 3, with tx_valid offered on the reset edge
        done_cnt = 0;
        bus.tx_data = 8'hFF; prescaler = 16'd4; bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        repeat (17) @(negedge clock);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1; bus.tx_valid = 1'b1;
        @(negedge clock);
        chk("mid_reset", {tx_pin, busy, done, bus.tx_ready}, 4'b1001);
        reset = 1'b0; bus.tx_valid = 1'b0;
        @(negedge clock);
        chk("valid_ignored_in_reset", busy, 0);
        repeat (20) @(negedge clock);
        chk("no_done_after_abort", done_cnt, 0);

        // 5-bit build, P=1
        bus5.tx_data = 5'b10011; presc5 = 3'd1; bus5.tx_valid = 1'b1;
        @(negedge clock);
        bus5.tx_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            line5[i] = tx_pin5;
            if (i == 6) chk("d5_done", done5, 1);
            if (i < 6) @(negedge clock);
        end
        chk("d5_line", line5, 7'b1100110);
        repeat (2) @(negedge clock);

        // 5-bit build at the largest 3-bit prescaler
        bus5.tx_data = 5'b01010; presc5 = 3'd7; bus5.tx_valid = 1'b1;
        @(negedge clock);
        bus5.tx_valid = 1'b0;
        n = 0;
        while (busy5 && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("d5_pmax_len", n, 49);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            bus.tx_valid = ($urandom_range(0, 2) != 0);
            bus.tx_data  = 8'($urandom);
            prescaler    = 16'($urandom_range(0, 5));
            parity_mode  = 2'($urandom);
            two_stop     = 1'($urandom);
            @(negedge clock);
        end
        reset = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (200) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
